// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: instruction classes, PC select codes, sequencer states
package cpu_pkg;

  localparam logic [1:0] ITYPE_R    = 2'd0;
  localparam logic [1:0] ITYPE_J    = 2'd1;
  localparam logic [1:0] ITYPE_HALT = 2'd2;
  localparam logic [1:0] ITYPE_I    = 2'd3;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_JUMP   = 2'd1;
  localparam logic [1:0] PC_BRANCH = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STALL,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  // Bits needed to hold the larger of two preload values (count - 1).
  function automatic int cnt_bits(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - ID/EX status in, pipeline control out
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic             start;
  logic             id_valid;
  logic [1:0]       id_type;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_rt_is_src;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             ex_branch_taken;
  logic             pc_en;
  logic [1:0]       pc_sel;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             running;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output start, id_valid, id_type, id_rs, id_rt, id_rt_is_src,
           ex_mem_read, ex_rd, ex_branch_taken,
    input  pc_en, pc_sel, if_id_en, if_id_flush, id_ex_bubble,
           running, halted, stall_cnt
  );

  modport slave (
    input  start, id_valid, id_type, id_rs, id_rt, id_rt_is_src,
           ex_mem_read, ex_rd, ex_branch_taken,
    output pc_en, pc_sel, if_id_en, if_id_flush, id_ex_bubble,
           running, halted, stall_cnt
  );
endinterface

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use compare between EX load and ID sources
module load_use_detect (
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rd,
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_rt_is_src,
  output logic       o_hazard
);
  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (i_ex_rd == i_id_rs);
  assign w_rt_match = i_id_rt_is_src & (i_ex_rd == i_id_rt);
  // $zero is never a real dependency.
  assign o_hazard   = i_ex_mem_read & (i_ex_rd != 5'd0) & i_id_valid
                    & (w_rs_match | w_rt_match);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline sequencer: PC/IF-ID gating, bubbles, flushes and HALT drain
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int LOAD_STALL   = 1,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int               CW         = cnt_bits(LOAD_STALL, DRAIN_CYCLES);
  localparam logic [CW-1:0]    CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]    STALL_LOAD = CW'(LOAD_STALL - 1);
  localparam logic [CW-1:0]    DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SCNT_MAX   = '1;
  localparam logic [CNT_W-1:0] SCNT_ONE   = CNT_W'(1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  state_t           w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [CNT_W-1:0] w_stall_cnt_nxt;
  logic             w_count_stall;
  logic             w_hazard;
  logic             w_is_jump;
  logic             w_is_halt;

  load_use_detect u_load_use_detect (
    .i_ex_mem_read  (bus.ex_mem_read),
    .i_ex_rd        (bus.ex_rd),
    .i_id_valid     (bus.id_valid),
    .i_id_rs        (bus.id_rs),
    .i_id_rt        (bus.id_rt),
    .i_id_rt_is_src (bus.id_rt_is_src),
    .o_hazard       (w_hazard)
  );

  assign w_is_jump = bus.id_valid & (bus.id_type == ITYPE_J);
  assign w_is_halt = bus.id_valid & (bus.id_type == ITYPE_HALT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_count_stall = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!bus.ex_branch_taken) begin
          if (w_hazard) begin
            w_count_stall = 1'b1;
            if (LOAD_STALL > 1) begin
              w_cnt_nxt   = STALL_LOAD;
              w_state_nxt = ST_STALL;
            end
          end else if (w_is_halt && !w_is_jump) begin
            w_cnt_nxt   = DRAIN_LOAD;
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_STALL: begin
        if (bus.ex_branch_taken) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_RUN;
        end else begin
          w_count_stall = 1'b1;
          // Exit on the cycle the counter steps down to zero.
          if (r_cnt <= CNT_ONE) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_RUN;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
      end
      ST_DRAIN: begin
        if (bus.ex_branch_taken) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_RUN;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_HALTED;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      ST_HALTED: begin
        w_state_nxt = ST_HALTED;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_stall_cnt_nxt = (w_count_stall && (r_stall_cnt != SCNT_MAX))
                         ? r_stall_cnt + SCNT_ONE : r_stall_cnt;

  always_comb begin
    bus.pc_en        = 1'b0;
    bus.pc_sel       = PC_SEQ;
    bus.if_id_en     = 1'b0;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_bubble = 1'b1;
    case (r_state)
      ST_RUN: begin
        if (bus.ex_branch_taken) begin
          bus.pc_en       = 1'b1;
          bus.pc_sel      = PC_BRANCH;
          bus.if_id_flush = 1'b1;
        end else if (w_hazard || w_is_halt) begin
          bus.id_ex_bubble = 1'b1;
        end else if (w_is_jump) begin
          bus.pc_en        = 1'b1;
          bus.pc_sel       = PC_JUMP;
          bus.if_id_en     = 1'b1;
          bus.if_id_flush  = 1'b1;
          bus.id_ex_bubble = 1'b0;
        end else begin
          bus.pc_en        = 1'b1;
          bus.if_id_en     = 1'b1;
          bus.id_ex_bubble = 1'b0;
        end
      end
      ST_STALL, ST_DRAIN: begin
        // A taken branch proves the stalled/halting instruction was wrong-path.
        if (bus.ex_branch_taken) begin
          bus.pc_en       = 1'b1;
          bus.pc_sel      = PC_BRANCH;
          bus.if_id_flush = 1'b1;
        end
      end
      default: begin
        bus.pc_en = 1'b0;
      end
    endcase
  end

  assign bus.running   = (r_state == ST_RUN) || (r_state == ST_STALL);
  assign bus.halted    = (r_state == ST_HALTED);
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and randomized checks of pipe_hazard_ctrl against a reference model
module tb_pipe_hazard_ctrl;
  localparam int TB_LOAD_STALL = 2;
  localparam int TB_DRAIN      = 3;
  localparam int TB_CNT_W      = 4;
  localparam int TB_CNT_MAX    = (1 << TB_CNT_W) - 1;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  bit m_valid;
  bit m_started;
  bit m_halted;
  int m_stall_left;
  int m_drain_left;
  int m_stalls;

  pipe_hazard_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

  pipe_hazard_ctrl #(
    .LOAD_STALL   (TB_LOAD_STALL),
    .DRAIN_CYCLES (TB_DRAIN),
    .CNT_W        (TB_CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: each cycle decides the expected outputs from the pending stall/drain
  // work and the current inputs, then advances that pending work.
  task automatic model_and_check();
    bit       hz;
    bit       e_pc_en, e_if_en, e_flush, e_bub, e_run, e_halt;
    int       e_sel;
    int       e_cnt;
    hz = bus.ex_mem_read && (bus.ex_rd != 5'd0) && bus.id_valid &&
         ((bus.ex_rd == bus.id_rs) || (bus.id_rt_is_src && (bus.ex_rd == bus.id_rt)));
    e_pc_en = 0; e_if_en = 0; e_flush = 0; e_bub = 1; e_sel = 0;
    e_run   = m_started && !m_halted && (m_drain_left == 0);
    e_halt  = m_halted;
    e_cnt   = (m_stalls > TB_CNT_MAX) ? TB_CNT_MAX : m_stalls;
    if (!m_started) begin
      if (bus.start) m_started = 1;
    end else if (m_halted) begin
      e_bub = 1;
    end else if (bus.ex_branch_taken) begin
      e_pc_en = 1; e_sel = 2; e_flush = 1;
      m_stall_left = 0;
      m_drain_left = 0;
    end else if (m_stall_left > 0) begin
      m_stalls++;
      m_stall_left--;
    end else if (m_drain_left > 0) begin
      m_drain_left--;
      if (m_drain_left == 0) m_halted = 1;
    end else if (hz) begin
      m_stalls++;
      m_stall_left = TB_LOAD_STALL - 1;
    end else if (bus.id_valid && bus.id_type == 2'd1) begin
      e_pc_en = 1; e_sel = 1; e_if_en = 1; e_flush = 1; e_bub = 0;
    end else if (bus.id_valid && bus.id_type == 2'd2) begin
      m_drain_left = TB_DRAIN;
    end else begin
      e_pc_en = 1; e_if_en = 1; e_bub = 0;
    end
    if (m_valid) begin
      chk("m_pc_en", bus.pc_en, e_pc_en);
      chk("m_pc_sel", bus.pc_sel, e_sel);
      chk("m_if_id_en", bus.if_id_en, e_if_en);
      chk("m_if_id_flush", bus.if_id_flush, e_flush);
      chk("m_id_ex_bubble", bus.id_ex_bubble, e_bub);
      chk("m_running", bus.running, e_run);
      chk("m_halted", bus.halted, e_halt);
      chk("m_stall_cnt", bus.stall_cnt, e_cnt);
    end
    if (!rst_n) begin
      m_valid = 1; m_started = 0; m_halted = 0;
      m_stall_left = 0; m_drain_left = 0; m_stalls = 0;
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic valid, input logic [1:0] ty,
                      input logic [4:0] rs, input logic [4:0] rt, input logic src,
                      input logic mr, input logic [4:0] rd, input logic br);
    @(negedge clk);
    rst_n = rst;
    bus.start = st; bus.id_valid = valid; bus.id_type = ty;
    bus.id_rs = rs; bus.id_rt = rt; bus.id_rt_is_src = src;
    bus.ex_mem_read = mr; bus.ex_rd = rd; bus.ex_branch_taken = br;
    #1;
    model_and_check();
  endtask

  task automatic nop();
    step(1, 0, 1, 2'd3, 5'd1, 5'd2, 0, 0, 5'd0, 0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_valid = 0; m_started = 0; m_halted = 0;
    m_stall_left = 0; m_drain_left = 0; m_stalls = 0;
    rst_n = 0;

    step(0, 0, 0, 2'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0);
    step(0, 0, 0, 2'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0);
    step(1, 0, 0, 2'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0);
    chk("rst_pc_en", bus.pc_en, 0);
    chk("rst_bubble", bus.id_ex_bubble, 1);
    chk("rst_running", bus.running, 0);
    chk("rst_stall_cnt", bus.stall_cnt, 0);

    step(1, 1, 0, 2'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0);
    nop();
    chk("start_running", bus.running, 1);
    chk("start_pc_en", bus.pc_en, 1);
    chk("start_pc_sel", bus.pc_sel, 0);

    step(1, 0, 1, 2'd0, 5'd5, 5'd7, 1, 1, 5'd5, 0);
    chk("hz1_pc_en", bus.pc_en, 0);
    step(1, 0, 1, 2'd0, 5'd5, 5'd7, 1, 1, 5'd5, 0);
    chk("hz2_bubble", bus.id_ex_bubble, 1);
    nop();
    chk("hz_resume_pc_en", bus.pc_en, 1);
    chk("hz_stall_cnt", bus.stall_cnt, 2);
    step(1, 0, 1, 2'd0, 5'd0, 5'd7, 1, 1, 5'd0, 0);
    chk("rd0_pc_en", bus.pc_en, 1);

    step(1, 0, 1, 2'd1, 5'd3, 5'd4, 0, 0, 5'd0, 0);
    chk("jump_pc_sel", bus.pc_sel, 1);
    chk("jump_flush", bus.if_id_flush, 1);
    chk("jump_bubble", bus.id_ex_bubble, 0);

    step(1, 0, 1, 2'd0, 5'd6, 5'd7, 1, 1, 5'd6, 1);
    chk("br_hz_pc_sel", bus.pc_sel, 2);
    chk("br_hz_pc_en", bus.pc_en, 1);
    nop();
    chk("br_hz_stall_cnt", bus.stall_cnt, 2);
    chk("br_hz_pc_en_next", bus.pc_en, 1);

    step(1, 0, 1, 2'd2, 5'd0, 5'd0, 0, 0, 5'd0, 0);
    nop(); nop(); nop();
    chk("drain_halted", bus.halted, 0);
    nop();
    chk("halt_halted", bus.halted, 1);
    chk("halt_pc_en", bus.pc_en, 0);
    step(1, 1, 0, 2'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0);
    nop();
    chk("halt_sticky", bus.halted, 1);

    step(0, 0, 0, 2'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0);
    step(1, 1, 0, 2'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0);
    step(1, 0, 1, 2'd2, 5'd0, 5'd0, 0, 0, 5'd0, 0);
    nop();
    step(1, 0, 1, 2'd3, 5'd1, 5'd2, 0, 0, 5'd0, 1);
    chk("drain_br_pc_sel", bus.pc_sel, 2);
    nop();
    chk("drain_br_running", bus.running, 1);
    chk("drain_br_halted", bus.halted, 0);

    step(0, 0, 0, 2'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0);
    step(1, 1, 0, 2'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0);
    step(1, 0, 1, 2'd0, 5'd9, 5'd9, 1, 1, 5'd9, 0);
    step(0, 0, 1, 2'd0, 5'd9, 5'd9, 1, 1, 5'd9, 0);
    nop();
    chk("rst_stall_pc_en", bus.pc_en, 0);
    chk("rst_stall_cnt", bus.stall_cnt, 0);
    chk("rst_stall_running", bus.running, 0);

    for (int i = 0; i < 3000; i++) begin
      logic [1:0] ty;
      int         r;
      r  = $urandom_range(0, 31);
      ty = (r == 0) ? 2'd2 : (r < 6) ? 2'd1 : ($urandom_range(0, 1) != 0) ? 2'd0 : 2'd3;
      step(logic'($urandom_range(0, 59) != 0), logic'($urandom_range(0, 3) == 0),
           logic'($urandom_range(0, 4) != 0), ty,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           logic'($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage MIPS-32 core; sits beside the ID stage.
- Gates PC and IF/ID updates, inserts ID/EX bubbles, flushes on jump/taken branch, and drains the pipe on HALT.
- Inputs: the ID-stage instruction class and register fields, plus EX-stage load and branch status.
- Owns start-up (IDLE until start), load-use stall counting and a saturating stall counter.

Parameters:
- LOAD_STALL, 1, bubbles inserted per load-use hazard (>=1).
- DRAIN_CYCLES, 3, cycles to retire in-flight EX/MEM/WB work after HALT.
- CNT_W, 16, width of stall_cnt.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  leave IDLE, begin fetching
- id_valid  in  1  ID holds a real instruction
- id_type  in  2  instruction class: R=0, J=1, HALT=2, I=3
- id_rs  in  5  ID source register
- id_rt  in  5  ID target register
- id_rt_is_src  in  1  rt is read (R-type, store, branch)
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  5  EX destination register
- ex_branch_taken  in  1  EX resolved a taken branch
- pc_en  out  1  PC register load enable
- pc_sel  out  2  0=PC+4, 1=jump target (ID), 2=branch target (EX)
- if_id_en  out  1  IF/ID register load enable
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_bubble  out  1  load NOP into ID/EX
- running  out  1  state is RUN or STALL
- halted  out  1  state is HALTED
- stall_cnt  out  CNT_W  stall cycles, saturating

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, counters=0. All outputs 0, except id_ex_bubble=1.
- Outputs are combinational from state and current inputs. The state, the down-counter and stall_cnt are registered.
- hazard = ex_mem_read & (ex_rd!=0) & id_valid & (ex_rd==id_rs | (id_rt_is_src & ex_rd==id_rt)).
- IDLE:
  - pc_en=0, if_id_en=0, id_ex_bubble=1.
  - start=1 -> RUN next cycle.
- RUN: evaluate in priority order, first match wins.
  1. ex_branch_taken: pc_en=1, pc_sel=2, if_id_flush=1, id_ex_bubble=1. Stay RUN.
  2. hazard: pc_en=0, if_id_en=0, id_ex_bubble=1, stall_cnt+1. If LOAD_STALL>1, load the counter with LOAD_STALL-1 and go to STALL; else stay RUN.
  3. id_valid & id_type==J: pc_en=1, pc_sel=1, if_id_en=1, if_id_flush=1. The jump itself proceeds to EX.
  4. id_valid & id_type==HALT: pc_en=0, if_id_en=0, id_ex_bubble=1, counter=DRAIN_CYCLES-1, go to DRAIN.
  5. Otherwise: pc_en=1, pc_sel=0, if_id_en=1.
- STALL:
  - pc_en=0, if_id_en=0, id_ex_bubble=1, stall_cnt+1, counter decrements.
  - Counter reaches 0 -> RUN.
  - ex_branch_taken overrides the stall: apply rule 1 and go to RUN immediately.
- DRAIN:
  - pc_en=0, if_id_en=0, id_ex_bubble=1, counter decrements; at 0 -> HALTED.
  - ex_branch_taken (HALT was on the wrong path): apply rule 1 and go to RUN.
- HALTED:
  - All enables 0, id_ex_bubble=1, halted=1.
  - Sticky until reset; start is ignored.
- id_valid=0 in RUN: no hazard, J or HALT action; normal advance.
- stall_cnt counts only hazard/STALL cycles, not IDLE or DRAIN. It saturates at all-ones, with no wrap.
- Reset mid-STALL or mid-DRAIN: state returns to IDLE next cycle and counters clear.
- Worst-case latency from the hazard cycle back to normal fetch: LOAD_STALL cycles.

Decomposition:
- Shared package cpu_pkg holds:
  - the instruction-class constants (R=0, J=1, HALT=2, I=3), shared with the decoder;
  - the pc_sel encodings (PC_SEQ=0, PC_JUMP=1, PC_BRANCH=2);
  - the state encoding (IDLE, RUN, STALL, DRAIN, HALTED).
- One sub-module, load_use_detect: the purely combinational hazard compare. It is reusable by a future forwarding unit.

Test Plan:
- Reset, then start=1 -> cycle after start: running=1, pc_en=1, pc_sel=0, stall_cnt=0.
- EX load with ex_rd=5, ID R-type with id_rs=5 (LOAD_STALL=2) -> pc_en=0 and id_ex_bubble=1 for exactly 2 cycles, then pc_en=1; stall_cnt=2. Repeat with ex_rd=0 -> no stall.
- ID J instruction -> one cycle of pc_sel=1, if_id_flush=1, pc_en=1; no bubble.
- Simultaneous ex_branch_taken and hazard -> pc_sel=2, if_id_flush=1, id_ex_bubble=1, pc_en=1; no STALL entry and stall_cnt unchanged.
- ID HALT -> DRAIN for 3 cycles, then halted=1 with all enables 0. A start pulse after that leaves halted=1.
- ID HALT, then ex_branch_taken in the 2nd DRAIN cycle -> back to RUN with pc_sel=2, halted never asserted.
- rst_n=0 during STALL -> next cycle state=IDLE, pc_en=0, stall_cnt=0.
